// File: rtl/counter_ctrl.sv
// ============================================================================
// counter_ctrl : bus-side load/readback controller for the counter_x timer,
//                with auto-reload arbitration and latched expiry interrupts.
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_ctrl #(
  parameter int LOAD_HOLD   = 4,
  parameter int RD_WAIT     = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_we,
  input  logic        bus_rd,
  output logic [31:0] bus_rdata,
  output logic        bus_rd_valid,
  output logic        bus_ready,
  output logic        counter_we,
  output logic [31:0] counter_val,
  output logic [1:0]  counter_ch,
  input  logic [31:0] counter_out,
  input  logic        counter0_out,
  input  logic        counter1_out,
  input  logic        counter2_out,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    GAP  = 2'd2,
    RSEL = 2'd3
  } state_t;

  state_t                         state_q, state_d;
  logic [2:0][31:0]               reload_q, reload_d;
  logic [2:0]                     ar_q, ar_d, ie_q, ie_d;
  logic [2:0]                     status_q, status_d, pend_q, pend_d;
  logic [2:0][SYNC_STAGES-1:0]    sync_q, sync_d;
  logic [2:0]                     prev_q, prev_d;
  logic [7:0]                     cnt_q, cnt_d;
  logic                           counter_we_q, counter_we_d;
  logic [31:0]                    counter_val_q, counter_val_d;
  logic [1:0]                     counter_ch_q, counter_ch_d;
  logic [31:0]                    bus_rdata_q, bus_rdata_d;
  logic                           bus_rd_valid_q, bus_rd_valid_d;
  logic                           irq_q, irq_d;

  logic       wr_acc, rd_acc;
  logic [1:0] rd_ch, sel;
  logic [2:0] exp_in, rise, req, clr;

  always_comb begin
    state_d        = state_q;
    reload_d       = reload_q;
    ar_d           = ar_q;
    ie_d           = ie_q;
    status_d       = status_q;
    cnt_d          = cnt_q;
    counter_we_d   = 1'b0;
    counter_val_d  = counter_val_q;
    counter_ch_d   = counter_ch_q;
    bus_rdata_d    = bus_rdata_q;
    bus_rd_valid_d = 1'b0;
    irq_d          = |(status_q & ie_q);
    req            = 3'b000;
    clr            = 3'b000;
    sel            = 2'd0;

    wr_acc = bus_we && (state_q == IDLE);
    rd_acc = bus_rd && (state_q == IDLE);
    rd_ch  = bus_addr[1:0] - 2'd1;
    exp_in = {counter2_out, counter1_out, counter0_out};

    for (int n = 0; n < 3; n++) begin
      sync_d[n][0] = exp_in[n];
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_d[n][s] = sync_q[n][s-1];
      end
      prev_d[n] = sync_q[n][SYNC_STAGES-1];
      rise[n]   = sync_q[n][SYNC_STAGES-1] & ~prev_q[n];
    end

    if (wr_acc) begin
      case (bus_addr)
        3'd0, 3'd1, 3'd2: begin
          reload_d[bus_addr[1:0]] = bus_wdata;
          req[bus_addr[1:0]]      = 1'b1;
        end
        3'd3: begin
          ar_d = bus_wdata[2:0];
          ie_d = bus_wdata[6:4];
        end
        3'd4:    status_d = status_q & ~bus_wdata[2:0];
        default: ;
      endcase
    end
    // A new expiry edge beats a simultaneous write-1-to-clear.
    status_d = status_d | rise;
    req      = req | (rise & ar_q);

    case (state_q)
      IDLE: begin
        if (rd_acc && (bus_addr >= 3'd5)) begin
          state_d      = RSEL;
          counter_ch_d = rd_ch;
          cnt_d        = 8'(RD_WAIT - 1);
        end else if (|pend_q) begin
          sel           = pend_q[0] ? 2'd0 : (pend_q[1] ? 2'd1 : 2'd2);
          state_d       = LOAD;
          counter_ch_d  = sel;
          counter_val_d = reload_q[sel];
          counter_we_d  = 1'b1;
          cnt_d         = 8'(LOAD_HOLD - 1);
          clr[sel]      = 1'b1;
        end
        if (rd_acc && (bus_addr < 3'd5)) begin
          bus_rd_valid_d = 1'b1;
          case (bus_addr)
            3'd3:    bus_rdata_d = {25'd0, ie_q, 1'b0, ar_q};
            3'd4:    bus_rdata_d = {29'd0, status_q};
            default: bus_rdata_d = reload_q[bus_addr[1:0]];
          endcase
        end
      end
      LOAD: begin
        if (cnt_q == 8'd0) begin
          state_d = GAP;
        end else begin
          counter_we_d = 1'b1;
          cnt_d        = cnt_q - 8'd1;
        end
      end
      GAP: state_d = IDLE;
      RSEL: begin
        if (cnt_q == 8'd0) begin
          bus_rdata_d    = counter_out;
          bus_rd_valid_d = 1'b1;
          state_d        = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Requests arriving in the LOAD-entry cycle survive the clear.
    pend_d = (pend_q & ~clr) | req;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      reload_q       <= '0;
      ar_q           <= '0;
      ie_q           <= '0;
      status_q       <= '0;
      pend_q         <= '0;
      sync_q         <= '0;
      prev_q         <= '0;
      cnt_q          <= '0;
      counter_we_q   <= 1'b0;
      counter_val_q  <= '0;
      counter_ch_q   <= '0;
      bus_rdata_q    <= '0;
      bus_rd_valid_q <= 1'b0;
      irq_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      reload_q       <= reload_d;
      ar_q           <= ar_d;
      ie_q           <= ie_d;
      status_q       <= status_d;
      pend_q         <= pend_d;
      sync_q         <= sync_d;
      prev_q         <= prev_d;
      cnt_q          <= cnt_d;
      counter_we_q   <= counter_we_d;
      counter_val_q  <= counter_val_d;
      counter_ch_q   <= counter_ch_d;
      bus_rdata_q    <= bus_rdata_d;
      bus_rd_valid_q <= bus_rd_valid_d;
      irq_q          <= irq_d;
    end
  end

  assign bus_ready    = (state_q == IDLE);
  assign counter_we   = counter_we_q;
  assign counter_val  = counter_val_q;
  assign counter_ch   = counter_ch_q;
  assign bus_rdata    = bus_rdata_q;
  assign bus_rd_valid = bus_rd_valid_q;
  assign irq          = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_counter_ctrl.sv
// ============================================================================
// tb_counter_ctrl : scoreboard bench for counter_ctrl loads, reads and irqs.
// Revision        : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic        bus_we = 1'b0;
  logic        bus_rd = 1'b0;
  logic [31:0] bus_rdata;
  logic        bus_rd_valid;
  logic        bus_ready;
  logic        counter_we;
  logic [31:0] counter_val;
  logic [1:0]  counter_ch;
  logic [31:0] counter_out;
  logic        counter0_out = 1'b0;
  logic        counter1_out = 1'b0;
  logic        counter2_out = 1'b0;
  logic        irq;

  typedef struct {
    logic [1:0]  ch;
    logic [31:0] val;
  } load_t;

  load_t       load_q[$];
  logic [31:0] rd_q[$];
  int          n_checks = 0;
  int          n_fails  = 0;
  int          we_len   = 0;
  logic        we_prev  = 1'b0;

  counter_ctrl #(.LOAD_HOLD(4), .RD_WAIT(2), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_rd(bus_rd), .bus_rdata(bus_rdata),
    .bus_rd_valid(bus_rd_valid), .bus_ready(bus_ready),
    .counter_we(counter_we), .counter_val(counter_val), .counter_ch(counter_ch),
    .counter_out(counter_out), .counter0_out(counter0_out),
    .counter1_out(counter1_out), .counter2_out(counter2_out), .irq(irq)
  );

  always #5 clk = ~clk;

  // Model of the counter_x readback mux.
  assign counter_out = (counter_ch == 2'd0) ? 32'hA0A0 :
                       (counter_ch == 2'd1) ? 32'h1234 : 32'hC2C2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard: pop expected loads on each rising counter_we, reads on bus_rd_valid.
  always @(negedge clk) begin
    if (reset) begin
      we_prev = 1'b0;
      we_len  = 0;
    end else begin
      if (counter_we && !we_prev) begin
        check("load_expected", 32'(load_q.size() != 0), 32'd1);
        if (load_q.size() != 0) begin
          load_t e;
          e = load_q.pop_front();
          check("load_ch", 32'(counter_ch), 32'(e.ch));
          check("load_val", counter_val, e.val);
        end
      end
      if (counter_we) we_len++;
      if (!counter_we && we_prev) begin
        check("load_hold_len", we_len, 32'd4);
        we_len = 0;
      end
      we_prev = counter_we;
      if (bus_rd_valid) begin
        check("rd_expected", 32'(rd_q.size() != 0), 32'd1);
        if (rd_q.size() != 0) check("rd_data", bus_rdata, rd_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus_ready) check("ready_timeout", 32'(bus_ready), 32'd1);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    wait_ready();
    bus_addr  = a;
    bus_wdata = d;
    bus_we    = 1'b1;
    tick();
    bus_we    = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [31:0] exp);
    rd_q.push_back(exp);
    wait_ready();
    bus_addr = a;
    bus_rd   = 1'b1;
    tick();
    bus_rd   = 1'b0;
  endtask

  task automatic settle();
    int n = 0;
    while ((load_q.size() != 0 || rd_q.size() != 0 || !bus_ready || counter_we) && n < 80) begin
      tick();
      n++;
    end
    if (n >= 80) check("settle_queues", load_q.size() + rd_q.size(), 32'd0);
  endtask

  task automatic push_load(input logic [1:0] ch, input logic [31:0] val);
    load_t e;
    e.ch  = ch;
    e.val = val;
    load_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=0x%08h exp=0x%08h", n_checks, 0);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values before any clock edge.
    #3;
    check("rst_ready", 32'(bus_ready), 32'd1);
    check("rst_we", 32'(counter_we), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rdata", bus_rdata, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Single CPU load with exact timing.
    push_load(2'd1, 32'h64);
    bus_write(3'd1, 32'h64);
    check("t2_ready_c0", 32'(bus_ready), 32'd1);
    for (int i = 1; i <= 6; i++) begin
      tick();
      check($sformatf("t2_we_c%0d", i), 32'(counter_we), 32'(i <= 4));
      check($sformatf("t2_ready_c%0d", i), 32'(bus_ready), 32'(i == 6));
      check($sformatf("t2_ch_c%0d", i), 32'(counter_ch), 32'd1);
    end
    check("t2_val", counter_val, 32'h64);
    settle();

    // Register readback, CTRL masking, ignored COUNT write.
    bus_read(3'd1, 32'h64);
    bus_write(3'd3, 32'hFFFF_FFFF);
    check("ctrl_wr_ready", 32'(bus_ready), 32'd1);
    bus_read(3'd3, 32'h77);
    bus_write(3'd3, 32'h0);
    bus_write(3'd5, 32'hDEAD);
    check("cnt_wr_ready", 32'(bus_ready), 32'd1);
    settle();

    // Expiry with auto-reload and irq, then W1C.
    push_load(2'd0, 32'hA5);
    bus_write(3'd0, 32'hA5);
    settle();
    bus_write(3'd3, 32'h11);
    push_load(2'd0, 32'hA5);
    counter0_out = 1'b1;
    tick(); tick(); tick();
    counter0_out = 1'b0;
    for (int i = 0; i < 8 && !irq; i++) tick();
    check("t3_irq_set", 32'(irq), 32'd1);
    settle();
    bus_read(3'd4, 32'h1);
    bus_write(3'd4, 32'h1);
    tick(); tick();
    check("t3_irq_clr", 32'(irq), 32'd0);
    bus_read(3'd4, 32'h0);
    settle();

    // Simultaneous expiries ch0 and ch2: loads in priority order.
    push_load(2'd2, 32'h222);
    bus_write(3'd2, 32'h222);
    settle();
    push_load(2'd0, 32'h100);
    bus_write(3'd0, 32'h100);
    settle();
    bus_write(3'd3, 32'h05);
    push_load(2'd0, 32'h100);
    push_load(2'd2, 32'h222);
    counter0_out = 1'b1;
    counter2_out = 1'b1;
    tick(); tick(); tick();
    counter0_out = 1'b0;
    counter2_out = 1'b0;
    settle();
    bus_read(3'd4, 32'h5);
    settle();

    // COUNT read: channel select held RD_WAIT cycles before capture.
    rd_q.push_back(32'h1234);
    wait_ready();
    bus_addr = 3'd6;
    bus_rd   = 1'b1;
    tick();
    bus_rd   = 1'b0;
    check("t5_ch_r0", 32'(counter_ch), 32'd1);
    check("t5_ready_r0", 32'(bus_ready), 32'd0);
    check("t5_valid_r0", 32'(bus_rd_valid), 32'd0);
    tick();
    check("t5_ch_r1", 32'(counter_ch), 32'd1);
    check("t5_valid_r1", 32'(bus_rd_valid), 32'd0);
    tick();
    check("t5_valid_r2", 32'(bus_rd_valid), 32'd1);
    check("t5_rdata_r2", bus_rdata, 32'h1234);
    settle();
    bus_read(3'd7, 32'hC2C2);
    bus_read(3'd5, 32'hA0A0);
    settle();

    // W1C landing on the same edge as a synced expiry: set wins.
    bus_write(3'd3, 32'h0);
    bus_write(3'd4, 32'h7);
    settle();
    counter1_out = 1'b1;
    tick();
    tick();
    bus_addr  = 3'd4;
    bus_wdata = 32'h2;
    bus_we    = 1'b1;
    tick();
    bus_we    = 1'b0;
    counter1_out = 1'b0;
    tick(); tick();
    bus_read(3'd4, 32'h2);
    bus_write(3'd4, 32'h2);
    bus_read(3'd4, 32'h0);
    settle();

    // Two ch1 expiries while ch1 already pending behind a ch0 load: one load.
    push_load(2'd1, 32'h55);
    bus_write(3'd1, 32'h55);
    settle();
    bus_write(3'd3, 32'h02);
    push_load(2'd0, 32'h300);
    push_load(2'd1, 32'h55);
    bus_write(3'd0, 32'h300);
    counter1_out = 1'b1;
    tick();
    counter1_out = 1'b0;
    tick();
    counter1_out = 1'b1;
    tick();
    counter1_out = 1'b0;
    settle();
    for (int i = 0; i < 15; i++) tick();
    check("t6_no_extra_load", load_q.size(), 32'd0);
    bus_write(3'd3, 32'h0);

    // Async reset mid-LOAD.
    push_load(2'd1, 32'h77);
    bus_write(3'd1, 32'h77);
    tick();
    tick();
    check("t1_pre_we", 32'(counter_we), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t1_we", 32'(counter_we), 32'd0);
    check("t1_ready", 32'(bus_ready), 32'd1);
    check("t1_ch", 32'(counter_ch), 32'd0);
    check("t1_val", counter_val, 32'd0);
    check("t1_irq", 32'(irq), 32'd0);
    check("t1_valid", 32'(bus_rd_valid), 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    bus_read(3'd1, 32'h0);
    settle();
    check("final_load_q", load_q.size(), 32'd0);
    check("final_rd_q", rd_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
